// File: rtl/digit_serial_addsub_pkg.sv
// -----------------------------------------------------------------------------
// digit_serial_addsub_pkg
// Shared definitions for the digit-serial adder/subtractor:
//   - state_e      : control FSM encoding (IDLE=0, RUN=1, DONE=2)
//   - calc_ndig    : number of DIGIT-bit slices in a WIDTH-bit operand
//   - calc_idx_w   : width of the slice index register (never below 1 bit)
//   - full_add     : one full-adder cell, returns {cout, s}
// -----------------------------------------------------------------------------
package digit_serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int calc_idx_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

    // Full-adder cell: result is {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic [1:0] r;
        r[0] = a ^ b ^ c;
        r[1] = (a & b) | (a & c) | (b & c);
        return r;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
// Purely combinational DIGIT-bit ripple chain of full-adder cells.
// Ports:
//   a, b  : DIGIT-bit addends
//   cin   : carry into bit 0
//   s     : DIGIT-bit sum
//   cout  : carry out of bit DIGIT-1
//   cmsb  : carry into bit DIGIT-1 (XOR with cout gives signed overflow)
// -----------------------------------------------------------------------------
module digit_adder
    import digit_serial_addsub_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] c_s;

    // Ripple the carry through DIGIT full-adder cells.
    always_comb begin
        c_s    = '0;
        s      = '0;
        c_s[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            {c_s[i+1], s[i]} = full_add(a[i], b[i], c_s[i]);
        end
    end

    assign cout = c_s[DIGIT];
    assign cmsb = c_s[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// -----------------------------------------------------------------------------
// digit_serial_addsub
// Multi-cycle adder/subtractor: processes WIDTH-bit operands one DIGIT-bit
// slice per clock, LSB first, with the inter-slice carry held in a register.
// Latency from an accepted start to done is NDIG+1 cycles (NDIG=WIDTH/DIGIT).
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     begin an operation (accepted only in IDLE or DONE)
//   sub       0: op1+op2, 1: op1-op2 (sampled with start)
//   op1, op2  WIDTH-bit operands (sampled with start)
//   busy      high while slices are being computed
//   done      one-cycle pulse when the result is valid
//   sum       result, held until the next accepted start
//   carry     carry out of the MSB (subtract: 1 = no borrow)
//   overflow  two's-complement overflow
//   zero      (only with ADDSUB_ZERO_FLAG_EN) result == 0, valid with done
//
// Optional feature macro: ADDSUB_ZERO_FLAG_EN
// -----------------------------------------------------------------------------
module digit_serial_addsub
    import digit_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
`ifdef ADDSUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int IDX_W = calc_idx_w(NDIG);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    if ((WIDTH % DIGIT) != 0) begin : g_param_check
        $fatal(1, "digit_serial_addsub: DIGIT must divide WIDTH exactly");
    end

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NDIG-1:0][DIGIT-1:0]  opa_q, opa_d;
    logic [NDIG-1:0][DIGIT-1:0]  opb_q, opb_d;
    logic [NDIG-1:0][DIGIT-1:0]  sum_q, sum_d;
    logic                        cy_q, cy_d;
    logic                        carry_q, carry_d;
    logic                        ovf_q, ovf_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
`ifdef ADDSUB_ZERO_FLAG_EN
    logic                        zacc_q, zacc_d;
    logic                        zero_q, zero_d;
`endif

    logic [DIGIT-1:0]            dig_s;
    logic                        dig_cout_s;
    logic                        dig_cmsb_s;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a    (opa_q[idx_q]),
        .b    (opb_q[idx_q]),
        .cin  (cy_q),
        .s    (dig_s),
        .cout (dig_cout_s),
        .cmsb (dig_cmsb_s)
    );

    // Next-state, datapath update and output-register decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cy_d    = cy_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
        zacc_d  = zacc_q;
        zero_d  = zero_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtract as op1 + ~op2 + 1: the +1 enters as the first carry.
                    state_d = ST_RUN;
                    idx_d   = '0;
                    opa_d   = op1;
                    opb_d   = sub ? ~op2 : op2;
                    cy_d    = sub;
                    busy_d  = 1'b1;
`ifdef ADDSUB_ZERO_FLAG_EN
                    zacc_d  = 1'b1;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d[idx_q] = dig_s;
                cy_d         = dig_cout_s;
`ifdef ADDSUB_ZERO_FLAG_EN
                zacc_d       = zacc_q & (dig_s == '0);
`endif
                if (idx_q == IDX_LAST) begin
                    // Flags come from the top slice only.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    carry_d = dig_cout_s;
                    ovf_d   = dig_cout_s ^ dig_cmsb_s;
`ifdef ADDSUB_ZERO_FLAG_EN
                    zero_d  = zacc_q & (dig_s == '0);
`endif
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
            zacc_q  <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cy_q    <= cy_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ADDSUB_ZERO_FLAG_EN
            zacc_q  <= zacc_d;
            zero_q  <= zero_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
`ifdef ADDSUB_ZERO_FLAG_EN
    assign zero     = zero_q;
`endif

endmodule

// File: tb/tb_digit_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_digit_serial_addsub
// Scoreboard bench for digit_serial_addsub with WIDTH=8, DIGIT=4 (NDIG=2).
// Stimulus pushes the arithmetic result expected for each accepted start; a
// monitor pops and compares whenever done is seen. Directed cycle checks cover
// busy/done timing, ignored starts, back-to-back starts and mid-run reset.
// -----------------------------------------------------------------------------
module tb_digit_serial_addsub;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sub;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;
    logic         overflow;
`ifdef ADDSUB_ZERO_FLAG_EN
    logic         zero;
`endif

    digit_serial_addsub #(
        .WIDTH (W),
        .DIGIT (D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .op1      (op1),
        .op2      (op2),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow)
`ifdef ADDSUB_ZERO_FLAG_EN
        ,
        .zero     (zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
        logic       z;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
        exp_t e;
        int   ua, ub, sa, sb, r, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            r  = ua - ub + 256;
            sr = sa - sb;
        end else begin
            r  = ua + ub;
            sr = sa + sb;
        end
        e.s = 8'(r);
        e.c = (r >= 256);
        e.v = (sr > 127) || (sr < -128);
        e.z = (e.s == 8'h00);
        return e;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
                e = q.pop_front();
                chk8("sum", sum, e.s);
                chk1("carry", carry, e.c);
                chk1("overflow", overflow, e.v);
`ifdef ADDSUB_ZERO_FLAG_EN
                chk1("zero", zero, e.z);
`endif
            end
        end
    end

    // Drive start for one cycle (call at a negedge while the DUT accepts),
    // then scramble operands to show later changes have no effect.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
        op1   = a;
        op2   = b;
        sub   = s;
        start = 1'b1;
        q.push_back(model(a, b, s));
        @(negedge clk);
        start = 1'b0;
        op1   = 8'($urandom);
        op2   = 8'($urandom);
        sub   = 1'($urandom);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 12) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done expected done within 12 cycles", name);
        end
    endtask

    // Issue and check busy/done per cycle; returns in the done cycle.
    task automatic timed_op(input string name, input logic [7:0] a, input logic [7:0] b, input logic s);
        issue(a, b, s);
        chk1({name, "_busy_t1"}, busy, 1'b1);
        chk1({name, "_done_t1"}, done, 1'b0);
        @(negedge clk);
        chk1({name, "_busy_t2"}, busy, 1'b1);
        chk1({name, "_done_t2"}, done, 1'b0);
        @(negedge clk);
        chk1({name, "_busy_t3"}, busy, 1'b0);
        chk1({name, "_done_t3"}, done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ra, rb;
        logic       rs;

        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        op1   = 8'h00;
        op2   = 8'h00;
        repeat (2) @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk8("rst_sum", sum, 8'h00);
        chk1("rst_carry", carry, 1'b0);
        chk1("rst_ovf", overflow, 1'b0);
`ifdef ADDSUB_ZERO_FLAG_EN
        chk1("rst_zero", zero, 1'b0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Basic add with cycle-exact timing, then result held in IDLE.
        timed_op("add0f01", 8'h0F, 8'h01, 1'b0);
        @(negedge clk);
        chk8("sum_hold", sum, 8'h10);
        chk1("done_pulse", done, 1'b0);

        // Flag corners.
        issue(8'h7F, 8'h01, 1'b0); wait_done("ovf_add"); @(negedge clk);
        issue(8'hFF, 8'h01, 1'b0); wait_done("wrap_add"); @(negedge clk);
        issue(8'h05, 8'h07, 1'b1); wait_done("borrow_sub"); @(negedge clk);
        issue(8'h80, 8'h01, 1'b1); wait_done("ovf_sub"); @(negedge clk);

        // Second start while busy is ignored.
        op1   = 8'h11;
        op2   = 8'h22;
        sub   = 1'b0;
        start = 1'b1;
        q.push_back(model(8'h11, 8'h22, 1'b0));
        @(negedge clk);
        op1   = 8'h01;
        op2   = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore");
        chk8("ignore_sum", sum, 8'h33);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("ignore_no_extra_done", done, 1'b0);
        end

        // Back-to-back: start in the done cycle.
        issue(8'h01, 8'h02, 1'b0);
        wait_done("b2b_first");
        timed_op("b2b", 8'h10, 8'h10, 1'b0);
        @(negedge clk);

        // Reset mid-run after a result with carry=1.
        issue(8'hF0, 8'h20, 1'b0); wait_done("pre_reset"); @(negedge clk);
        issue(8'h55, 8'h22, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        chk8("mid_rst_sum", sum, 8'h00);
        chk1("mid_rst_carry", carry, 1'b0);
        chk1("mid_rst_ovf", overflow, 1'b0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("mid_rst_no_done", done, 1'b0);
        end
        issue(8'h0F, 8'h01, 1'b0); wait_done("post_reset"); @(negedge clk);

        // Randomised operations with random idle gaps or back-to-back starts.
        for (int n = 0; n < 60; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            issue(ra, rb, rs);
            wait_done("rand");
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
            end
        end

        repeat (4) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drained: got %0d pending expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
- Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands one DIGIT-bit slice per clock, LSB first.
- Each slice is computed by a ripple chain of full-adder cells, and the slice carry is held in a register between cycles.
- Trades latency for area in the datapath experiments.
- Sits behind a start/busy/done handshake driven by a control unit.

Parameters:
- WIDTH, 32, operand and result width in bits.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly. NDIG = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only when accepting.
- sub  input  1  0 = op1+op2, 1 = op1-op2; sampled with start.
- op1  input  WIDTH  first operand; sampled with start.
- op2  input  WIDTH  second operand; sampled with start.
- busy  output  1  high while slices are being computed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held until the next accepted start.
- carry  output  1  carry out of the MSB (for subtract: 1 = no borrow).
- overflow  output  1  two's-complement overflow.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, carry=0, overflow=0, digit index=0.
  - Applies immediately, including mid-operation. The partial result is discarded and no done is produced.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> RUN while index < NDIG-1; RUN -> DONE after slice NDIG-1.
  - DONE -> RUN if start=1, otherwise DONE -> IDLE.
- Accept:
  - start is accepted in IDLE or DONE, in cycle T.
  - At T: latch op1 and (sub ? ~op2 : op2) into operand registers, set carry register = sub, index = 0.
- Run:
  - Cycles T+1 .. T+NDIG have busy=1.
  - Each cycle adds slice [index*DIGIT +: DIGIT] plus the carry register.
  - The slice sum is written to the same slice of the sum register, then the carry register updates and index increments.
- Completion:
  - Cycle T+NDIG+1: done=1 for exactly one cycle, busy=0.
  - sum, carry and overflow are valid and stable from this cycle until the next accept.
  - Latency from accept to done is NDIG+1 cycles.
- Flags:
  - carry = carry out of bit WIDTH-1.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. It is captured on the final slice.
- Handshake corner cases:
  - start while busy=1 is ignored; no queueing.
  - start in the DONE cycle is accepted, giving back-to-back operation. done is still asserted that cycle.
  - Operand changes after accept have no effect.
  - sum is updated slice by slice during RUN. Consumers use sum only when done=1 or afterwards.
- Arithmetic is modulo 2^WIDTH. No saturation.

Optional Feature:
- Macro: ADDSUB_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero (1 bit, reset 0).
  - zero is registered with the final slice and valid with done: 1 iff the full WIDTH-bit result is 0.
  - It is held alongside sum.
  - Implemented as a running AND of per-slice zero detects.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared include file holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the NDIG computation macro;
  - a parameter check that DIGIT divides WIDTH (fatal message in simulation).
- Sub-module digit_adder:
  - Parametrised DIGIT-bit ripple chain of full-adder cells.
  - Ports: a, b, cin, s, cout, plus cmsb (carry into the top bit, used for overflow).
  - Purely combinational; all state lives in digit_serial_addsub.

Test Plan (WIDTH=8, DIGIT=4, NDIG=2; start accepted at T, done at T+3):
- 0x0F + 0x01, sub=0 -> sum=0x10, carry=0, overflow=0; busy at T+1..T+2; done exactly at T+3.
- 0x7F + 0x01 -> sum=0x80, carry=0, overflow=1. Then 0xFF + 0x01 -> sum=0x00, carry=1, overflow=0, zero=1 (macro on).
- sub=1: 0x05 - 0x07 -> sum=0xFE, carry=0 (borrow), overflow=0. Then 0x80 - 0x01 -> sum=0x7F, carry=1, overflow=1.
- start with 0x11+0x22 at T, second start with 0x01+0x01 at T+1 -> second ignored; done at T+3 with sum=0x33.
- Back-to-back: new start (0x10+0x10) asserted in the done cycle -> accepted; next done 3 cycles later with sum=0x20.
- reset pulsed at T+2 mid-run -> busy, done, sum and flags are 0 immediately; no done follows; next start works normally.
